// File: rtl/xbus_pkg.sv
// Shared types and constants for the xbus receive word aligner.
package xbus_pkg;

  typedef enum logic [1:0] {HUNT, VERIFY, ALIGNED} xbus_align_state_t;

  localparam logic [9:0] XBUS_SYNC_K285 = 10'h0FA;

  function automatic int xbus_off_w(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/xbus_pattern_search.sv
// Combinational W-offset comparator: match vector over a 2W window plus lowest-index encoder.
module xbus_pattern_search
  import xbus_pkg::*;
#(
  parameter int            W   = 10,
  parameter logic [W-1:0]  PAT = W'(XBUS_SYNC_K285),
  localparam int           OW  = xbus_off_w(W)
) (
  input  logic [2*W-1:0] win,
  output logic [W-1:0]   match,
  output logic           found,
  output logic [OW-1:0]  idx
);

  always_comb begin
    match = '0;
    for (int k = 0; k < W; k++) begin
      match[k] = (win[k +: W] == PAT);
    end
  end

  // Scan downwards so the lowest set bit is the one left in idx.
  always_comb begin
    found = |match;
    idx   = '0;
    for (int k = W - 1; k >= 0; k--) begin
      if (match[k]) idx = OW'(k);
    end
  end

endmodule

// File: rtl/xbus_rx_aligner.sv
// Receive word aligner: hunts for the sync word at every bit offset, verifies it, then emits aligned words.
// Optional build macro XBUS_ALIGN_INV_EN also accepts the bit-inverted sync pattern and adds inv_o.
module xbus_rx_aligner
  import xbus_pkg::*;
#(
  parameter int           W           = 10,
  parameter logic [W-1:0] SYNC_PAT    = W'(XBUS_SYNC_K285),
  parameter int           VERIFY_CNT  = 4,
  parameter int           REALIGN_CNT = 3,
  localparam int          OW          = xbus_off_w(W)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [W-1:0]  din_i,
  input  logic          din_vld_i,
  input  logic          resync_i,
  output logic [W-1:0]  dout_o,
  output logic          dout_vld_o,
  output logic          sync_o,
  output logic          aligned_o,
`ifdef XBUS_ALIGN_INV_EN
  output logic          inv_o,
`endif
  output logic [OW-1:0] offset_o
);

  localparam logic [3:0] VCNT_L = 4'(VERIFY_CNT);
  localparam logic [3:0] RCNT_L = 4'(REALIGN_CNT);

  function automatic logic [3:0] sat_inc(input logic [3:0] c);
    return (c == 4'hF) ? c : c + 4'd1;
  endfunction

  xbus_align_state_t state, state_nxt;
  logic [W-1:0]   prev_p0;
  logic [2*W-1:0] win;
  logic [OW-1:0]  off_q, off_nxt, sel_off;
  logic [3:0]     vcnt, vcnt_nxt, rcnt, rcnt_nxt;
  logic           inv_q, inv_nxt, sel_inv;
  logic           hit_any, hit_inv, cur_hit, latch;
  logic [OW-1:0]  hit_idx;
  logic [W-1:0]   cand, cand_out;
  logic [W-1:0]   dout_p1;
  logic           vld_p1, sync_p1;

  logic [W-1:0]   match_n;
  logic           found_n;
  logic [OW-1:0]  idx_n;

  assign win = {din_i, prev_p0};

  xbus_pattern_search #(.W(W), .PAT(SYNC_PAT)) u_search_n (
    .win   (win),
    .match (match_n),
    .found (found_n),
    .idx   (idx_n)
  );

`ifdef XBUS_ALIGN_INV_EN
  logic [W-1:0]  match_i;
  logic          found_i;
  logic [OW-1:0] idx_i;

  xbus_pattern_search #(.W(W), .PAT(~SYNC_PAT)) u_search_i (
    .win   (win),
    .match (match_i),
    .found (found_i),
    .idx   (idx_i)
  );

  // Candidates at one offset can never match both polarities, so ties are impossible.
  assign hit_any = found_n | found_i;
  assign hit_inv = !found_n || (found_i && (idx_i < idx_n));
  assign hit_idx = hit_inv ? idx_i : idx_n;
  assign cur_hit = inv_q ? match_i[off_q] : match_n[off_q];
  assign inv_o   = inv_q;
`else
  assign hit_any = found_n;
  assign hit_inv = 1'b0;
  assign hit_idx = idx_n;
  assign cur_hit = match_n[off_q];
`endif

  always_comb begin
    state_nxt = state;
    off_nxt   = off_q;
    inv_nxt   = inv_q;
    vcnt_nxt  = vcnt;
    rcnt_nxt  = rcnt;
    latch     = 1'b0;
    if (resync_i) begin
      state_nxt = HUNT;
      vcnt_nxt  = '0;
      rcnt_nxt  = '0;
    end else if (din_vld_i) begin
      case (state)
        HUNT: begin
          if (hit_any) begin
            latch     = 1'b1;
            off_nxt   = hit_idx;
            inv_nxt   = hit_inv;
            vcnt_nxt  = 4'd1;
            rcnt_nxt  = '0;
            state_nxt = (VERIFY_CNT <= 1) ? ALIGNED : VERIFY;
          end
        end
        VERIFY: begin
          if (cur_hit) begin
            vcnt_nxt = sat_inc(vcnt);
            if (sat_inc(vcnt) >= VCNT_L) begin
              state_nxt = ALIGNED;
              rcnt_nxt  = '0;
            end
          end else begin
            state_nxt = HUNT;
            vcnt_nxt  = '0;
          end
        end
        ALIGNED: begin
          if (cur_hit) begin
            rcnt_nxt = '0;
          end else if (hit_any) begin
            rcnt_nxt = sat_inc(rcnt);
            if (sat_inc(rcnt) >= RCNT_L) begin
              state_nxt = HUNT;
              vcnt_nxt  = '0;
              rcnt_nxt  = '0;
            end
          end
        end
        default: state_nxt = HUNT;
      endcase
    end
  end

  // A fresh lock steers this very word through the newly found offset and polarity.
  assign sel_off  = latch ? hit_idx : off_q;
  assign sel_inv  = latch ? hit_inv : inv_q;
  assign cand     = win[sel_off +: W];
  assign cand_out = sel_inv ? ~cand : cand;

  // Stage p0 -> p1: control state, previous word and registered aligned output.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= HUNT;
      off_q   <= '0;
      inv_q   <= 1'b0;
      vcnt    <= '0;
      rcnt    <= '0;
      prev_p0 <= '0;
      dout_p1 <= '0;
      vld_p1  <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      state   <= state_nxt;
      off_q   <= off_nxt;
      inv_q   <= inv_nxt;
      vcnt    <= vcnt_nxt;
      rcnt    <= rcnt_nxt;
      vld_p1  <= din_vld_i;
      sync_p1 <= din_vld_i && (cand_out == SYNC_PAT);
      if (din_vld_i) begin
        prev_p0 <= din_i;
        dout_p1 <= cand_out;
      end
    end
  end

  assign dout_o     = dout_p1;
  assign dout_vld_o = vld_p1;
  assign sync_o     = sync_p1;
  assign aligned_o  = (state == ALIGNED);
  assign offset_o   = off_q;

endmodule
